// File: rtl/cpu_defs.sv
// ============================================================================
// Module  : cpu_defs
// Brief   : Shared core-wide widths and types for the decoder, ROB, RS and
//           register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_W     = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [ROB_W-1:0]     rob_tag_t;
  typedef logic [31:0]          word_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/reg_file_if.sv
// ============================================================================
// Module  : reg_file_if
// Brief   : Decoder query, issue-rename and ROB commit/rollback bundle of the
//           register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_if;
  import cpu_defs::*;

  logic     rdy;
  logic     rollback;

  reg_idx_t rs1_index;
  word_t    rs1_value;
  logic     rs1_dirty;
  rob_tag_t rs1_rob_entry;

  reg_idx_t rs2_index;
  word_t    rs2_value;
  logic     rs2_dirty;
  rob_tag_t rs2_rob_entry;

  logic     issue_valid;
  reg_idx_t issue_rd;
  rob_tag_t issue_rob_entry;

  logic     commit_valid;
  reg_idx_t commit_rd;
  rob_tag_t commit_rob_entry;
  word_t    commit_value;

  modport master (
    output rdy, rollback,
    output rs1_index, rs2_index,
    input  rs1_value, rs1_dirty, rs1_rob_entry,
    input  rs2_value, rs2_dirty, rs2_rob_entry,
    output issue_valid, issue_rd, issue_rob_entry,
    output commit_valid, commit_rd, commit_rob_entry, commit_value
  );

  modport slave (
    input  rdy, rollback,
    input  rs1_index, rs2_index,
    output rs1_value, rs1_dirty, rs1_rob_entry,
    output rs2_value, rs2_dirty, rs2_rob_entry,
    input  issue_valid, issue_rd, issue_rob_entry,
    input  commit_valid, commit_rd, commit_rob_entry, commit_value
  );

endinterface

`default_nettype wire

// File: rtl/reg_read_port.sv
// ============================================================================
// Module  : reg_read_port
// Brief   : One combinational operand query: x0 forcing, lookup and commit
//           bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_read_port
  import cpu_defs::*;
(
  input  reg_idx_t             index_i,
  input  word_t                regs_value_i [REG_NUM],
  input  logic [REG_NUM-1:0]   regs_dirty_i,
  input  rob_tag_t             regs_tag_i   [REG_NUM],
  input  logic                 commit_valid_i,
  input  reg_idx_t             commit_rd_i,
  input  rob_tag_t             commit_rob_entry_i,
  input  word_t                commit_value_i,
  output word_t                value_o,
  output logic                 dirty_o,
  output rob_tag_t             rob_entry_o
);

  logic w_bypass;

  always_comb begin
    w_bypass    = 1'b0;
    value_o     = '0;
    dirty_o     = 1'b0;
    rob_entry_o = '0;
    if (index_i != ZERO_REG) begin
      // Only a commit from the current owner may be forwarded; stale producers fall through.
      w_bypass    = commit_valid_i && (commit_rd_i == index_i) &&
                    regs_dirty_i[index_i] &&
                    (regs_tag_i[index_i] == commit_rob_entry_i);
      value_o     = w_bypass ? commit_value_i : regs_value_i[index_i];
      dirty_o     = regs_dirty_i[index_i] && !w_bypass;
      rob_entry_o = regs_tag_i[index_i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module  : reg_file
// Brief   : Architectural register file with rename status, commit write-back
//           and rollback flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
  import cpu_defs::*;
(
  input  logic         clk,
  input  logic         rst,
  reg_file_if.slave    rf_bus
);

  word_t              value_q [REG_NUM];
  word_t              value_d [REG_NUM];
  logic [REG_NUM-1:0] dirty_q;
  logic [REG_NUM-1:0] dirty_d;
  rob_tag_t           tag_q   [REG_NUM];
  rob_tag_t           tag_d   [REG_NUM];

  always_comb begin
    value_d = value_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (rf_bus.rdy) begin
      if (rf_bus.commit_valid && (rf_bus.commit_rd != ZERO_REG)) begin
        value_d[rf_bus.commit_rd] = rf_bus.commit_value;
        if (tag_q[rf_bus.commit_rd] == rf_bus.commit_rob_entry)
          dirty_d[rf_bus.commit_rd] = 1'b0;
      end
      // Rename is applied last so a same-cycle issue keeps the register dirty.
      if (rf_bus.rollback) begin
        dirty_d = '0;
      end else if (rf_bus.issue_valid && (rf_bus.issue_rd != ZERO_REG)) begin
        dirty_d[rf_bus.issue_rd] = 1'b1;
        tag_d[rf_bus.issue_rd]   = rf_bus.issue_rob_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      dirty_q <= '0;
    end else begin
      value_q <= value_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

  reg_read_port u_rs1_port (
    .index_i            (rf_bus.rs1_index),
    .regs_value_i       (value_q),
    .regs_dirty_i       (dirty_q),
    .regs_tag_i         (tag_q),
    .commit_valid_i     (rf_bus.commit_valid),
    .commit_rd_i        (rf_bus.commit_rd),
    .commit_rob_entry_i (rf_bus.commit_rob_entry),
    .commit_value_i     (rf_bus.commit_value),
    .value_o            (rf_bus.rs1_value),
    .dirty_o            (rf_bus.rs1_dirty),
    .rob_entry_o        (rf_bus.rs1_rob_entry)
  );

  reg_read_port u_rs2_port (
    .index_i            (rf_bus.rs2_index),
    .regs_value_i       (value_q),
    .regs_dirty_i       (dirty_q),
    .regs_tag_i         (tag_q),
    .commit_valid_i     (rf_bus.commit_valid),
    .commit_rd_i        (rf_bus.commit_rd),
    .commit_rob_entry_i (rf_bus.commit_rob_entry),
    .commit_value_i     (rf_bus.commit_value),
    .value_o            (rf_bus.rs2_value),
    .dirty_o            (rf_bus.rs2_dirty),
    .rob_entry_o        (rf_bus.rs2_rob_entry)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module  : tb_reg_file
// Brief   : Directed self-checking bench for reg_file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;
  import cpu_defs::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  reg_file_if rf_if ();

  reg_file u_dut (
    .clk    (clk),
    .rst    (rst),
    .rf_bus (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_if.issue_valid  = 1'b0;
    rf_if.commit_valid = 1'b0;
    rf_if.rollback     = 1'b0;
  endtask

  task automatic do_issue(input reg_idx_t rd, input rob_tag_t e);
    rf_if.issue_valid     = 1'b1;
    rf_if.issue_rd        = rd;
    rf_if.issue_rob_entry = e;
  endtask

  task automatic do_commit(input reg_idx_t rd, input rob_tag_t e, input word_t v);
    rf_if.commit_valid     = 1'b1;
    rf_if.commit_rd        = rd;
    rf_if.commit_rob_entry = e;
    rf_if.commit_value     = v;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    rf_if.rdy = 1'b1;
    idle();
    rf_if.issue_rd = '0; rf_if.issue_rob_entry = '0;
    rf_if.commit_rd = '0; rf_if.commit_rob_entry = '0; rf_if.commit_value = '0;
    rf_if.rs1_index = 5'd5;
    rf_if.rs2_index = 5'd0;
    #2;
    check("rst_rs1_value", rf_if.rs1_value, 32'h0);
    check("rst_rs1_dirty", 32'(rf_if.rs1_dirty), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("q5_value", rf_if.rs1_value, 32'h0);
    check("q5_dirty", 32'(rf_if.rs1_dirty), 32'h0);
    check("q0_value", rf_if.rs2_value, 32'h0);
    check("q0_dirty", 32'(rf_if.rs2_dirty), 32'h0);

    // issue then commit with bypass
    do_issue(5'd3, 4'd7);
    tick(); idle();
    rf_if.rs1_index = 5'd3;
    #1;
    check("r3_dirty", 32'(rf_if.rs1_dirty), 32'h1);
    check("r3_entry", 32'(rf_if.rs1_rob_entry), 32'h7);
    do_commit(5'd3, 4'd7, 32'hDEADBEEF);
    #1;
    check("r3_byp_value", rf_if.rs1_value, 32'hDEADBEEF);
    check("r3_byp_dirty", 32'(rf_if.rs1_dirty), 32'h0);
    tick(); idle();
    #1;
    check("r3_st_value", rf_if.rs1_value, 32'hDEADBEEF);
    check("r3_st_dirty", 32'(rf_if.rs1_dirty), 32'h0);

    // stale commit after re-rename
    do_issue(5'd4, 4'd2);
    tick();
    do_issue(5'd4, 4'd9);
    tick(); idle();
    do_commit(5'd4, 4'd2, 32'h11);
    rf_if.rs2_index = 5'd4;
    #1;
    check("r4_nobyp_value", rf_if.rs2_value, 32'h0);
    check("r4_nobyp_dirty", 32'(rf_if.rs2_dirty), 32'h1);
    tick(); idle();
    #1;
    check("r4_value", rf_if.rs2_value, 32'h11);
    check("r4_dirty", 32'(rf_if.rs2_dirty), 32'h1);
    check("r4_entry", 32'(rf_if.rs2_rob_entry), 32'h9);

    // same-cycle issue and commit
    do_issue(5'd6, 4'd1);
    tick(); idle();
    do_commit(5'd6, 4'd1, 32'h55);
    do_issue(5'd6, 4'd3);
    tick(); idle();
    rf_if.rs1_index = 5'd6;
    #1;
    check("r6_value", rf_if.rs1_value, 32'h55);
    check("r6_dirty", 32'(rf_if.rs1_dirty), 32'h1);
    check("r6_entry", 32'(rf_if.rs1_rob_entry), 32'h3);

    // rdy low: issue and rollback both ignored
    rf_if.rdy = 1'b0;
    do_issue(5'd2, 4'd5);
    rf_if.rollback = 1'b1;
    tick(); idle();
    rf_if.rdy = 1'b1;
    rf_if.rs1_index = 5'd2;
    #1;
    check("rdy0_r2_dirty", 32'(rf_if.rs1_dirty), 32'h0);
    check("rdy0_r4_dirty", 32'(rf_if.rs2_dirty), 32'h1);

    // rollback with commit and issue
    do_issue(5'd8, 4'd4);
    tick();
    do_issue(5'd9, 4'd5);
    tick(); idle();
    rf_if.rollback = 1'b1;
    do_commit(5'd8, 4'd4, 32'hAA);
    do_issue(5'd10, 4'd6);
    tick(); idle();
    rf_if.rs1_index = 5'd8;
    rf_if.rs2_index = 5'd9;
    #1;
    check("rb_r8_value", rf_if.rs1_value, 32'hAA);
    check("rb_r8_dirty", 32'(rf_if.rs1_dirty), 32'h0);
    check("rb_r9_dirty", 32'(rf_if.rs2_dirty), 32'h0);
    rf_if.rs1_index = 5'd10;
    rf_if.rs2_index = 5'd6;
    #1;
    check("rb_r10_dirty", 32'(rf_if.rs1_dirty), 32'h0);
    check("rb_r6_dirty", 32'(rf_if.rs2_dirty), 32'h0);

    // x0 writes
    do_issue(5'd0, 4'd1);
    do_commit(5'd0, 4'd1, 32'h77);
    rf_if.rs1_index = 5'd0;
    #1;
    check("x0_byp_value", rf_if.rs1_value, 32'h0);
    tick(); idle();
    #1;
    check("x0_value", rf_if.rs1_value, 32'h0);
    check("x0_dirty", 32'(rf_if.rs1_dirty), 32'h0);

    // asynchronous reset pulse between edges
    do_issue(5'd12, 4'd8);
    tick(); idle();
    rf_if.rs1_index = 5'd3;
    rf_if.rs2_index = 5'd12;
    #1;
    check("pre_rst_r12_dirty", 32'(rf_if.rs2_dirty), 32'h1);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check("arst_r3_value", rf_if.rs1_value, 32'h0);
    check("arst_r12_dirty", 32'(rf_if.rs2_dirty), 32'h0);
    check("arst_r12_entry", 32'(rf_if.rs2_rob_entry), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
